icache_assoc: RTL and testbench
===============================

Name: icache_assoc

Overview:
- Parametrised set-associative, multi-word-block instruction cache. It sits between the datapath instruction-fetch port and the memory controller instruction port.
- Successor to the direct-mapped single-word icache. Adds configurable associativity with tree pseudo-LRU replacement, multi-word block fill, whole-cache flush, and hit/miss performance counters.
- Hits return data in the same cycle. Misses run a sequential block fill through the iREN/iwait handshake.

Parameters:
- SETS, 16, number of sets; power of 2, >=2.
- WAYS, 2, associativity; power of 2 in {1,2,4,8}.
- WORDS_PER_BLK, 2, 32-bit words per block; power of 2, >=1.
- CNT_W, 32, width of each performance counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits[1:0] ignored.
- halt  in  1  datapath halt; sticky until reset.
- flush  in  1  one-cycle pulse: invalidate whole cache.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  32  fetched instruction; valid when ihit=1.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iload  in  32  memory read data; valid when iwait=0.
- iwait  in  1  memory busy; a word is accepted on a cycle with iREN=1 and iwait=0.
- flush_done  out  1  one-cycle pulse when flush completes.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of fills started.

Behaviour:
- Address split, MSB to LSB: tag | idx (log2 SETS) | woff (log2 WORDS_PER_BLK) | 2'b00.
- Per set, each way holds: valid, tag, WORDS_PER_BLK data words. Each set also holds WAYS-1 PLRU bits. For WAYS=1 there are no PLRU bits and the victim is always way 0.
- Lookup is combinational in IDLE:
  - ihit = imemREN & ~halt & (some way valid with matching tag).
  - imemload = the selected word on a hit, else 0.
- Every ihit cycle updates that set's PLRU to point away from the hit way, and increments hit_count.
- States: IDLE, FILL, FLUSH, HALT.
- IDLE transitions, in priority order:
  - halt -> HALT.
  - flush -> FLUSH.
  - imemREN & miss -> FILL. On entry, latch tag/idx, reset word counter wc=0, pick the victim, and increment miss_count.
- Victim selection: the lowest-index invalid way in the set; otherwise the PLRU way.
- FILL:
  - iREN=1 and iaddr = {ltag, lidx, wc, 2'b00}.
  - On each cycle with iwait=0: write iload to victim word wc, then wc++.
  - iwait=1 holds wc and the request unchanged.
  - After the last word is accepted: set victim valid and tag, update PLRU to point away from the victim, go to IDLE. ihit stays 0 throughout FILL.
  - The following IDLE cycle hits if the request is unchanged. Miss-to-ihit latency is therefore WORDS_PER_BLK accepted words + 1 cycle.
- FILL boundary cases:
  - Changes to imemaddr/imemREN during FILL are ignored; the fill always completes.
  - flush during FILL is recorded and taken on return to IDLE, which then goes to FLUSH.
  - halt during FILL: the fill completes, then the block goes to HALT.
- FLUSH:
  - Clears valid and PLRU for one set per cycle, idx 0..SETS-1, taking SETS cycles.
  - flush_done=1 for exactly one cycle, coinciding with the last set clear; next state is IDLE.
  - ihit=0 and iREN=0 throughout. A flush pulse arriving while in FLUSH is ignored.
- HALT: terminal until RST. ihit=0, iREN=0. Cache contents are retained and counters are frozen.
- Counters saturate at all-ones and never wrap.
- Reset, including mid-FILL or mid-FLUSH:
  - State -> IDLE.
  - All valid and PLRU bits -> 0.
  - wc, pending flush, and both counters -> 0.
  - iREN=0, iaddr=0, flush_done=0, ihit=0, imemload=0.
  - Data and tag arrays need not be reset.
- iaddr = 0 whenever iREN=0.

Test Plan:
1. Cold miss, WAYS=2, WORDS_PER_BLK=2, iwait=0: fetch 0x100 -> iREN with iaddr 0x100, then 0x104; memory returns 0xAAAA0000/0xAAAA0001. The next cycle gives ihit=1, imemload=0xAAAA0000. A following fetch of 0x104 gives ihit=1, imemload=0xAAAA0001. miss_count=1, hit_count=2.
2. Conflict/LRU with SETS=16 and block 8 B (set stride 0x80): fill 0x000 then 0x080 into set 0, re-hit 0x000, then fetch 0x100 -> the way holding 0x080 is evicted. 0x000 still hits; 0x080 misses again.
3. Stall: iwait=1 for 3 cycles on each word -> iaddr holds each address during its stall. The fill completes after 8 cycles, plus 1 cycle to ihit. The loaded data is correct.
4. Flush: after cases 1-2, pulse flush -> flush_done pulses exactly 16 cycles later. Fetch 0x000 then gives ihit=0 and a new FILL; miss_count increments.
5. Reset mid-FILL: assert RST after the first word is accepted -> the next cycle shows iREN=0 and counters 0. Refetching the same address misses and performs a full 2-word fill.
6. Halt: assert halt during FILL -> the fill completes, then ihit=0 and iREN=0 forever, even when fetching an address already present in the cache; the counters do not change.

Source files
------------

// File: rtl/icache_assoc_if.sv
// ============================================================================
// icache_assoc_if : fetch-side and memory-side signal bundle of icache_assoc
// Revision 1.0
// ============================================================================
`default_nettype none

interface icache_assoc_if #(
  parameter int CNT_W = 32
);
  logic             imemREN;
  logic [31:0]      imemaddr;
  logic             halt;
  logic             flush;
  logic             ihit;
  logic [31:0]      imemload;
  logic             iREN;
  logic [31:0]      iaddr;
  logic [31:0]      iload;
  logic             iwait;
  logic             flush_done;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  // master = datapath plus memory controller; slave = the cache
  modport master (
    output imemREN, imemaddr, halt, flush, iload, iwait,
    input  ihit, imemload, iREN, iaddr, flush_done, hit_count, miss_count
  );

  modport slave (
    input  imemREN, imemaddr, halt, flush, iload, iwait,
    output ihit, imemload, iREN, iaddr, flush_done, hit_count, miss_count
  );
endinterface

`default_nettype wire

// File: rtl/icache_assoc.sv
// ============================================================================
// icache_assoc : set-associative multi-word-block icache, tree PLRU, flush
// Revision 1.0
// ============================================================================
`default_nettype none

module icache_assoc #(
  parameter int SETS          = 16,
  parameter int WAYS          = 2,
  parameter int WORDS_PER_BLK = 2,
  parameter int CNT_W         = 32
) (
  input  logic CLK,
  input  logic RST,
  icache_assoc_if.slave bus
);

  localparam int c_IDX_W = $clog2(SETS);
  localparam int c_OFF_W = $clog2(WORDS_PER_BLK);
  localparam int c_WC_W  = (c_OFF_W > 0) ? c_OFF_W : 1;
  localparam int c_LW    = $clog2(WAYS);
  localparam int c_WAY_W = (c_LW > 0) ? c_LW : 1;
  localparam int c_PL_W  = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int c_TAG_W = 30 - c_OFF_W - c_IDX_W;

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_FILL  = 2'd1;
  localparam logic [1:0] c_S_FLUSH = 2'd2;
  localparam logic [1:0] c_S_HALT  = 2'd3;

  // PLRU tree in heap order: bit=1 steers the victim to the right subtree
  function automatic logic [c_WAY_W-1:0] plru_victim(input logic [c_PL_W-1:0] t);
    int node;
    int v;
    int b;
    node = 0;
    v    = 0;
    for (int l = 0; l < c_LW; l++) begin
      b    = (int'(t) >> node) & 1;
      v    = (v << 1) | b;
      node = 2 * node + 1 + b;
    end
    return c_WAY_W'(v);
  endfunction

  function automatic logic [c_PL_W-1:0] plru_touch(input logic [c_PL_W-1:0] t,
                                                   input logic [c_WAY_W-1:0] w);
    logic [c_PL_W-1:0] r;
    int node;
    int b;
    r    = t;
    node = 0;
    for (int l = 0; l < c_LW; l++) begin
      b    = (int'(w) >> (c_LW - 1 - l)) & 1;
      r    = (r & ~(c_PL_W'(1) << node)) | (c_PL_W'(b == 0) << node);
      node = 2 * node + 1 + b;
    end
    return r;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [WAYS-1:0]    valid_q [SETS];
  logic [c_PL_W-1:0]  plru_q  [SETS];
  logic [c_TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [31:0]        data_q  [SETS][WAYS][WORDS_PER_BLK];
  logic [c_TAG_W-1:0] ltag_q;
  logic [c_IDX_W-1:0] lidx_q;
  logic [c_WAY_W-1:0] victim_q;
  logic [c_WC_W-1:0]  wc_q;
  logic [c_IDX_W-1:0] fidx_q;
  logic               flush_pend_q;
  logic               halt_pend_q;
  logic [CNT_W-1:0]   hit_count_q;
  logic [CNT_W-1:0]   miss_count_q;

  logic [29:0]        w_word;
  logic [c_WC_W-1:0]  w_woff;
  logic [c_IDX_W-1:0] w_idx;
  logic [c_TAG_W-1:0] w_tag;
  logic [WAYS-1:0]    w_hit_vec;
  logic               w_any_hit;
  logic [c_WAY_W-1:0] w_hit_way;
  logic               w_any_inv;
  logic [c_WAY_W-1:0] w_inv_way;
  logic [c_WAY_W-1:0] w_victim;
  logic               w_halt_req;
  logic               w_flush_req;
  logic               w_ihit;
  logic               w_accept;
  logic               w_last;
  logic               w_flush_last;
  logic [31:0]        w_fill_addr;

  assign w_word       = bus.imemaddr[31:2];
  assign w_woff       = c_WC_W'(w_word & 30'(WORDS_PER_BLK - 1));
  assign w_idx        = c_IDX_W'(w_word >> c_OFF_W);
  assign w_tag        = c_TAG_W'(w_word >> (c_OFF_W + c_IDX_W));
  assign w_halt_req   = bus.halt | halt_pend_q;
  assign w_flush_req  = bus.flush | flush_pend_q;
  assign w_accept     = (state_q == c_S_FILL) & ~bus.iwait;
  assign w_last       = (wc_q == c_WC_W'(WORDS_PER_BLK - 1));
  assign w_flush_last = (state_q == c_S_FLUSH) & (fidx_q == c_IDX_W'(SETS - 1));
  assign w_fill_addr  = (32'(ltag_q) << (2 + c_OFF_W + c_IDX_W))
                      | (32'(lidx_q) << (2 + c_OFF_W))
                      | (32'(wc_q) << 2);

  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    w_any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      w_hit_vec[w] = valid_q[w_idx][w] && (tag_q[w_idx][w] == w_tag);
    end
    // descending scan leaves the lowest-index match in place
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) w_hit_way = c_WAY_W'(w);
      if (!valid_q[w_idx][w]) begin
        w_inv_way = c_WAY_W'(w);
        w_any_inv = 1'b1;
      end
    end
    w_any_hit = |w_hit_vec;
    w_victim  = w_any_inv ? w_inv_way : plru_victim(plru_q[w_idx]);
    w_ihit    = (state_q == c_S_IDLE) & bus.imemREN & ~w_halt_req & w_any_hit;
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= c_S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_IDLE: begin
        if (w_halt_req)                     state_d = c_S_HALT;
        else if (w_flush_req)               state_d = c_S_FLUSH;
        else if (bus.imemREN && !w_any_hit) state_d = c_S_FILL;
      end
      c_S_FILL: begin
        if (w_accept && w_last) state_d = (w_halt_req) ? c_S_HALT : c_S_IDLE;
      end
      c_S_FLUSH: begin
        if (w_flush_last) state_d = c_S_IDLE;
      end
      default: state_d = c_S_HALT;
    endcase
  end

  // outputs
  always_comb begin
    bus.ihit       = w_ihit;
    bus.imemload   = w_ihit ? data_q[w_idx][w_hit_way][w_woff] : 32'h0;
    bus.iREN       = (state_q == c_S_FILL);
    bus.iaddr      = (state_q == c_S_FILL) ? w_fill_addr : 32'h0;
    bus.flush_done = w_flush_last;
    bus.hit_count  = hit_count_q;
    bus.miss_count = miss_count_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
      ltag_q       <= '0;
      lidx_q       <= '0;
      victim_q     <= '0;
      wc_q         <= '0;
      fidx_q       <= '0;
      flush_pend_q <= 1'b0;
      halt_pend_q  <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      halt_pend_q <= halt_pend_q | bus.halt;
      case (state_q)
        c_S_IDLE: begin
          if (w_ihit) begin
            plru_q[w_idx] <= plru_touch(plru_q[w_idx], w_hit_way);
            if (~&hit_count_q) hit_count_q <= hit_count_q + 1'b1;
          end
          if (state_d == c_S_FILL) begin
            ltag_q   <= w_tag;
            lidx_q   <= w_idx;
            victim_q <= w_victim;
            wc_q     <= '0;
            if (~&miss_count_q) miss_count_q <= miss_count_q + 1'b1;
          end
          if (state_d == c_S_FLUSH) begin
            flush_pend_q <= 1'b0;
            fidx_q       <= '0;
          end
        end
        c_S_FILL: begin
          if (bus.flush) flush_pend_q <= 1'b1;
          if (w_accept) begin
            if (w_last) begin
              wc_q                      <= '0;
              valid_q[lidx_q][victim_q] <= 1'b1;
              plru_q[lidx_q]            <= plru_touch(plru_q[lidx_q], victim_q);
            end else begin
              wc_q <= wc_q + 1'b1;
            end
          end
        end
        c_S_FLUSH: begin
          valid_q[fidx_q] <= '0;
          plru_q[fidx_q]  <= '0;
          fidx_q          <= fidx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // tag and data arrays carry no reset; valid bits qualify them
  always_ff @(posedge CLK) begin
    if (!RST && w_accept) begin
      data_q[lidx_q][victim_q][wc_q] <= bus.iload;
      if (w_last) tag_q[lidx_q][victim_q] <= ltag_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_assoc.sv
// ============================================================================
// tb_icache_assoc : directed self-checking bench for icache_assoc (16x2x2)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_icache_assoc;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  icache_assoc_if #(.CNT_W(32)) bus ();

  icache_assoc #(
    .SETS          (16),
    .WAYS          (2),
    .WORDS_PER_BLK (2),
    .CNT_W         (32)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // memory image: 0x100 -> 0xAAAA0000, 0x104 -> 0xAAAA0001, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] w;
    w = a[17:2];
    return {16'hAAAA, w - 16'h0040};
  endfunction

  always_comb bus.iload = mem_word(bus.iaddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_counts(input string tag, input int hits, input int misses);
    chk({tag, "_hits"}, bus.hit_count, 32'(hits));
    chk({tag, "_misses"}, bus.miss_count, 32'(misses));
  endtask

  // Fetch one word; on a miss walk the 2-word fill with `stall` wait cycles per word
  task automatic fetch(input logic [31:0] a, input bit miss, input int stall);
    logic [31:0] base;
    base         = a & ~32'h7;
    bus.imemREN  = 1'b1;
    bus.imemaddr = a;
    bus.iwait    = 1'b0;
    #1;
    if (miss) begin
      chk("miss_ihit", bus.ihit, 32'h0);
      cyc();
      for (int i = 0; i < 2; i++) begin
        for (int s = 0; s < stall; s++) begin
          bus.iwait = 1'b1;
          #1;
          chk("stall_iaddr", bus.iaddr, base + 32'(4 * i));
          chk("stall_iren", bus.iREN, 32'h1);
          cyc();
        end
        bus.iwait = 1'b0;
        #1;
        chk("fill_iaddr", bus.iaddr, base + 32'(4 * i));
        chk("fill_ihit", bus.ihit, 32'h0);
        cyc();
      end
      #1;
    end
    chk("hit_ihit", bus.ihit, 32'h1);
    chk("hit_data", bus.imemload, mem_word(a));
    cyc();
    bus.imemREN = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    RST          = 1'b1;
    bus.imemREN  = 1'b0;
    bus.imemaddr = 32'h0;
    bus.halt     = 1'b0;
    bus.flush    = 1'b0;
    bus.iwait    = 1'b0;
    repeat (2) cyc();
    #1;
    chk("rst_ihit", bus.ihit, 32'h0);
    chk("rst_iren", bus.iREN, 32'h0);
    chk("rst_iaddr", bus.iaddr, 32'h0);
    chk("rst_fdone", bus.flush_done, 32'h0);
    chk("rst_load", bus.imemload, 32'h0);
    chk_counts("rst", 0, 0);
    RST = 1'b0;
    cyc();

    // cold miss then hits in the same block
    fetch(32'h100, 1'b1, 0);
    fetch(32'h104, 1'b0, 0);
    chk("t1_word0", mem_word(32'h100), 32'hAAAA0000);
    chk_counts("t1", 2, 1);

    // set 0 conflicts: 0x080 is the PLRU victim when 0x100 returns
    fetch(32'h000, 1'b1, 0);
    fetch(32'h080, 1'b1, 0);
    fetch(32'h000, 1'b0, 0);
    fetch(32'h100, 1'b1, 0);
    fetch(32'h000, 1'b0, 0);
    fetch(32'h080, 1'b1, 0);
    chk_counts("t2", 8, 5);

    // stalled fill, set 1
    fetch(32'h20C, 1'b1, 3);
    chk_counts("t3", 9, 6);

    // whole-cache flush
    bus.flush = 1'b1;
    #1;
    chk("fl_done_early", bus.flush_done, 32'h0);
    cyc();
    bus.flush = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk("fl_done", bus.flush_done, 32'(k == 16));
      chk("fl_iren", bus.iREN, 32'h0);
      cyc();
    end
    fetch(32'h000, 1'b1, 0);
    chk_counts("t4", 10, 7);

    // reset after the first word of a fill
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h100;
    #1;
    chk("t5_miss", bus.ihit, 32'h0);
    cyc();
    #1;
    chk("t5_iaddr0", bus.iaddr, 32'h100);
    cyc();
    RST = 1'b1;
    #1;
    chk("t5_iaddr1", bus.iaddr, 32'h104);
    cyc();
    RST = 1'b0;
    #1;
    chk("t5_iren", bus.iREN, 32'h0);
    chk("t5_iaddr", bus.iaddr, 32'h0);
    chk("t5_ihit", bus.ihit, 32'h0);
    chk_counts("t5_rst", 0, 0);
    bus.imemREN = 1'b0;
    cyc();
    fetch(32'h100, 1'b1, 0);
    fetch(32'h000, 1'b1, 0);
    chk_counts("t5", 2, 2);

    // halt during a fill of 0x300 (evicts 0x100, keeps 0x000)
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h300;
    #1;
    chk("t6_miss", bus.ihit, 32'h0);
    cyc();
    bus.halt = 1'b1;
    #1;
    chk("t6_iren0", bus.iREN, 32'h1);
    chk("t6_iaddr0", bus.iaddr, 32'h300);
    cyc();
    #1;
    chk("t6_iaddr1", bus.iaddr, 32'h304);
    cyc();
    bus.imemaddr = 32'h000;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_ihit", bus.ihit, 32'h0);
      chk("t6_iren", bus.iREN, 32'h0);
      chk("t6_iaddr", bus.iaddr, 32'h0);
      chk_counts("t6", 2, 3);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
